// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg -- shared definitions for the HI/LO multiply unit.
//   op_e        : operation encodings carried on the 3-bit `op` port
//   mul_state_e : sequencing FSM states of mul_hilo_unit
//   DATA_W      : architectural register width
//   MUL_ITERS   : shift-add iterations per multiply
//   CNT_W       : width of the iteration counter
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_MADDU = 3'd2,
        OP_MADD  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } mul_state_e;

    // MULT and MADD treat operands as two's complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD);
    endfunction

endpackage

// File: rtl/mul_seq_core.sv
// ---------------------------------------------------------------------------
// mul_seq_core -- unsigned 32x32 shift-add multiplier, one iteration per step.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture mcand/mplier, clear product and counter
//   step       : perform one shift-add iteration
//   mcand      : multiplicand magnitude
//   mplier     : multiplier magnitude
//   product    : running 64-bit product (final after MUL_ITERS steps)
//   count      : number of iterations completed since load
// ---------------------------------------------------------------------------
module mul_seq_core
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_W-1:0]     mcand,
    input  logic [DATA_W-1:0]     mplier,
    output logic [2*DATA_W-1:0]   product,
    output logic [CNT_W-1:0]      count
);

    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] product_q;
    logic [CNT_W-1:0]    count_q;

    // Multiplicand shifts left while multiplier shifts right, so bit 0 of the
    // multiplier always selects whether the aligned multiplicand is added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            count_q   <= '0;
        end else if (load) begin
            mcand_q   <= {{DATA_W{1'b0}}, mcand};
            mplier_q  <= mplier;
            product_q <= '0;
            count_q   <= '0;
        end else if (step) begin
            if (mplier_q[0]) begin
                product_q <= product_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
        end
    end

    assign product = product_q;
    assign count   = count_q;

endmodule

// File: rtl/mul_hilo_unit.sv
// ---------------------------------------------------------------------------
// mul_hilo_unit -- MIPS-style HI/LO multiply/accumulate unit.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, op      : operation request and code (MULTU/MULT/MADDU/MADD/MTHI/MTLO)
//   rs_val, rt_val : operands
//   busy           : multi-cycle operation in flight (state != IDLE)
//   done           : one-cycle pulse, coincident with updated hi/lo
//   hi, lo         : architectural HI/LO registers
//   state_dbg      : current FSM state (mul_state_e encoding)
// Handshake: a request is taken on any rising edge where start=1 and the FSM
// is IDLE; start is ignored otherwise. Each accepted op yields exactly one
// done pulse unless reset intervenes.
// ---------------------------------------------------------------------------
module mul_hilo_unit
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [1:0]        state_dbg
);

    mul_state_e          state_q;
    logic [2:0]          op_q;
    logic                neg_q;
    logic                done_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;

    logic                accept_mul;
    logic                sgn;
    logic [DATA_W-1:0]   mag_rs;
    logic [DATA_W-1:0]   mag_rt;
    logic [2*DATA_W-1:0] core_product;
    logic [CNT_W-1:0]    core_count;
    logic [2*DATA_W-1:0] prod_signed;
    logic [2*DATA_W-1:0] result_d;

    assign accept_mul = (state_q == ST_IDLE) && start && (op <= OP_MADD);
    assign sgn        = is_signed_op(op);

    // Unsigned negation maps 0x80000000 onto itself, i.e. magnitude 2^31.
    assign mag_rs = (sgn && rs_val[DATA_W-1]) ? (~rs_val + 1'b1) : rs_val;
    assign mag_rt = (sgn && rt_val[DATA_W-1]) ? (~rt_val + 1'b1) : rt_val;

    mul_seq_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept_mul),
        .step    (state_q == ST_CALC),
        .mcand   (mag_rs),
        .mplier  (mag_rt),
        .product (core_product),
        .count   (core_count)
    );

    assign prod_signed = neg_q ? (~core_product + 1'b1) : core_product;
    assign result_d    = ((op_q == OP_MADDU) || (op_q == OP_MADD))
                         ? prod_signed + {hi_q, lo_q}
                         : prod_signed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULTU, OP_MULT, OP_MADDU, OP_MADD: begin
                                op_q    <= op;
                                neg_q   <= sgn && (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
                                state_q <= ST_CALC;
                            end
                            OP_MTHI: begin
                                hi_q   <= rs_val;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= rs_val;
                                done_q <= 1'b1;
                            end
                            default: ;  // reserved codes are dropped
                        endcase
                    end
                end
                ST_CALC: begin
                    // The step taken on this edge is the last one.
                    if (core_count == CNT_W'(MUL_ITERS - 1)) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    {hi_q, lo_q} <= result_d;
                    done_q       <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: doc/mul_hilo_unit.md
MUL_HILO_UNIT -- requirements
Module: mul_hilo_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock `clk`, reset `rst_n`.
REQ-002 Port `clk`: input, width 1, rising-edge clock for all state.
REQ-003 Port `rst_n`: input, width 1, asynchronous active-low reset.
REQ-004 Port `start`: input, width 1, operation request, sampled on rising edge.
REQ-005 Port `op`: input, width 3, operation code. 0=MULTU, 1=MULT, 2=MADDU, 3=MADD, 4=MTHI, 5=MTLO, 6-7 reserved.
REQ-006 Port `rs_val`: input, width 32, first operand.
REQ-007 Port `rt_val`: input, width 32, second operand.
REQ-008 Port `busy`: output, width 1, high while a multi-cycle operation is in flight.
REQ-009 Port `done`: output, width 1, one-cycle pulse when HI/LO hold the new result.
REQ-010 Port `hi`: output, width 32, architectural HI register, registered.
REQ-011 Port `lo`: output, width 32, architectural LO register, registered.

Function
REQ-012 The FSM SHALL have three states, IDLE, CALC and FINISH; `busy` SHALL equal (state != IDLE).
REQ-013 In IDLE, `start`=1 with op 0-3 SHALL latch rs_val/rt_val/op, clear the 6-bit iteration counter and the 64-bit product accumulator, and enter CALC.
REQ-014 CALC SHALL run one shift-add iteration per cycle on the 32-bit unsigned multiplicand/multiplier magnitudes, for exactly 32 cycles, then enter FINISH.
REQ-015 For MULT/MADD, the magnitudes SHALL be the two's-complement absolute values of the operands; the product SHALL be negated in FINISH when the operand signs differ. 0x80000000 SHALL be treated as magnitude 2^31.
REQ-016 FINISH SHALL write {hi,lo} as follows, in one cycle: MULT/MULTU = product; MADD/MADDU = product + {hi,lo}, wrapping mod 2^64 with no overflow flag. The block SHALL then return to IDLE.
REQ-017 `done` SHALL be 1 in the cycle after the FINISH edge, i.e. 34 cycles after the accepting edge, coincident with the updated hi/lo; it SHALL be 0 otherwise.
REQ-018 In IDLE, `start`=1 with op 4 (MTHI) or op 5 (MTLO) SHALL write rs_val to hi (or lo) on that edge. Busy SHALL stay 0, and `done` SHALL pulse in the following cycle.
REQ-019 In IDLE, `start`=1 with op 6-7 SHALL be ignored: no state change, no done.
REQ-020 While busy, `start` SHALL be ignored, and input changes SHALL NOT affect the in-flight result.
REQ-021 hi/lo SHALL change only in FINISH, on MTHI/MTLO, or on reset.
REQ-022 Back-to-back operation: `start` in the same cycle that `done` is high SHALL be accepted, because the state is IDLE then.

Reset
REQ-023 On rst_n=0, at any time, the block SHALL asynchronously force state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0 and accumulator=0.
REQ-024 Reset during CALC/FINISH SHALL abort the operation with no later done pulse and no partial hi/lo write.
REQ-025 The first `start` SHALL be honoured on the first rising edge after rst_n deasserts.

Structure
REQ-026 Shared package `mips_pkg` SHALL hold: the op encodings (MULTU..MTLO), the FSM state enum, and the constants DATA_W=32 and MUL_ITERS=32.
REQ-027 The 32-iteration unsigned shift-add datapath SHALL be a sub-module `mul_seq_core`, containing operand/product registers and the counter, with `load`/`step`/`product` ports. Sign handling, accumulation, HI/LO and the FSM SHALL reside in `mul_hilo_unit`.

Verification
REQ-028 MULTU, rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 cycles after the accepting edge; busy high 33 cycles.
REQ-029 MULT, rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-030 MTHI 0, MTLO 0xFFFFFFFF, then MADD 1*1 -> hi=0x00000001, lo=0x00000000; MTHI/MTLO each give a done pulse the next cycle with busy=0.
REQ-031 MTHI 0xFFFFFFFF, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=0, lo=0 (64-bit wrap); MADD -1*1 from {0,5} -> hi=0, lo=4.
REQ-032 Start MULTU 7*9, then pulse start with MTHI 0x1234 on cycle 5 of CALC (ignored), then assert rst_n=0 on cycle 10 -> hi=lo=0, busy=0 immediately, and no done within 40 cycles; after release, MULTU 7*9 -> lo=63.
